// File: rtl/router_input_stage_pkg.sv
// Shared flit layout and FSM state type for the router input stage.
package router_input_stage_pkg;

   localparam int FLIT_W    = 14;
   localparam int TAIL_BIT  = 13;
   localparam int ROUTE_BIT = 12;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

endpackage

// File: rtl/router_fifo.sv
// Input flit FIFO. Pointers carry one extra wrap bit so that full and empty
// are distinguishable without a separate occupancy counter.
module router_fifo #(
   parameter int DEPTH  = 8,
   parameter int FLIT_W = 14
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [FLIT_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [FLIT_W-1:0] rd_data,
   output logic              full,
   output logic              empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]       wr_ptr;
   logic [AW:0]       rd_ptr;
   logic [FLIT_W-1:0] mem [DEPTH];
   logic              do_wr;
   logic              do_rd;

   assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign empty   = (wr_ptr == rd_ptr);
   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;
   assign rd_data = mem[rd_ptr[AW-1:0]];

   // Pointer update; a simultaneous write and read leaves occupancy unchanged.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage array; contents need no reset because empty masks them.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/router_input_stage.sv
// Router input stage: buffers upstream flits, locks one output allocator per
// packet using the head flit's route bit, and releases it after the tail.
//
//   state | meaning
//   IDLE  | no packet locked; decode route of FIFO head when one is present
//   BUSY  | packet locked to req_<route>; forward flits until the tail leaves
module router_input_stage #(
   parameter int DEPTH  = 8,
   parameter int FLIT_W = 14
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [FLIT_W-1:0] in_data,
   output logic              in_ready,
   output logic              req_0,
   output logic              req_1,
   input  logic              ready_0,
   input  logic              ready_1,
   output logic              out_valid,
   output logic [FLIT_W-1:0] out_data,
   output logic [15:0]       pkt_count
);

   import router_input_stage_pkg::*;

   state_t            state;
   logic              route;
   logic              full;
   logic              empty;
   logic              wr_en;
   logic              xfer;
   logic [FLIT_W-1:0] head;
   logic [15:0]       pkt_count_q;

   assign in_ready  = !full && !reset;
   assign wr_en     = in_valid && in_ready;
   assign out_valid = (state == BUSY) && !empty;
   // Only the locked allocator's ready matters; the other one is ignored.
   assign xfer      = out_valid && (route ? ready_1 : ready_0);
   assign out_data  = head;
   assign pkt_count = pkt_count_q;

   router_fifo #(
      .DEPTH  (DEPTH),
      .FLIT_W (FLIT_W)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_data (in_data),
      .rd_en   (xfer),
      .rd_data (head),
      .full    (full),
      .empty   (empty)
   );

   // Packet lock FSM: route latched from the head in IDLE, request held
   // through body gaps and dropped the cycle after the tail transfers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         route <= 1'b0;
         req_0 <= 1'b0;
         req_1 <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!empty) begin
                  route <= head[ROUTE_BIT];
                  req_0 <= !head[ROUTE_BIT];
                  req_1 <= head[ROUTE_BIT];
                  state <= BUSY;
               end
            end
            BUSY: begin
               if (xfer && head[TAIL_BIT]) begin
                  req_0 <= 1'b0;
                  req_1 <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               req_0 <= 1'b0;
               req_1 <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   // Saturating count of packets whose tail has been forwarded.
   always_ff @(posedge clk) begin
      if (reset) begin
         pkt_count_q <= '0;
      end else if (xfer && head[TAIL_BIT] && (pkt_count_q != 16'hFFFF)) begin
         pkt_count_q <= pkt_count_q + 16'd1;
      end
   end

endmodule

// File: tb/tb_router_input_stage.sv
// Bench for router_input_stage: directed scenarios plus random packet traffic,
// checked by a scoreboard monitor against a queue-based reference model.
module tb_router_input_stage;

   localparam int DEPTH = 8;
   localparam int FW    = 14;

   logic          clk      = 1'b0;
   logic          reset    = 1'b1;
   logic          in_valid = 1'b0;
   logic [FW-1:0] in_data  = '0;
   logic          ready_0  = 1'b0;
   logic          ready_1  = 1'b0;
   logic          in_ready;
   logic          req_0;
   logic          req_1;
   logic          out_valid;
   logic [FW-1:0] out_data;
   logic [15:0]   pkt_count;

   typedef struct {
      logic [FW-1:0] data;
      logic          route;
   } ent_t;

   ent_t        exp_q[$];
   logic [15:0] pkt_mdl  = '0;
   logic        wr_head  = 1'b1;
   logic        wr_route = 1'b0;
   int          n_chk    = 0;
   int          n_err    = 0;
   int          xfer_cnt = 0;
   bit          rnd_on   = 1'b0;

   router_input_stage #(.DEPTH(DEPTH), .FLIT_W(FW)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .req_0     (req_0),
      .req_1     (req_1),
      .ready_0   (ready_0),
      .ready_1   (ready_1),
      .out_valid (out_valid),
      .out_data  (out_data),
      .pkt_count (pkt_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Drive one flit starting at a falling edge; returns at the falling edge
   // after the flit was written.
   task automatic send(input logic [FW-1:0] f);
      int n = 0;
      in_valid = 1'b1;
      in_data  = f;
      #1;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("send_timeout", n < 200, 1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check({name, "_drain"}, exp_q.size(), 0);
      repeat (2) @(negedge clk);
   endtask

   // Scoreboard monitor: samples just after the falling edge, i.e. the
   // values the next rising edge will act on.
   initial begin
      ent_t e;
      ent_t ne;
      forever begin
         @(negedge clk);
         #1;
         if (reset) begin
            check("in_ready_in_reset", in_ready, 0);
            exp_q.delete();
            pkt_mdl  = '0;
            wr_head  = 1'b1;
            wr_route = 1'b0;
         end else begin
            check("in_ready", in_ready, exp_q.size() < DEPTH);
            check("pkt_count", pkt_count, pkt_mdl);
            if (exp_q.size() == 0) check("out_valid_empty", out_valid, 0);
            if (out_valid && exp_q.size() != 0) begin
               e = exp_q[0];
               check("req_route", {req_1, req_0}, e.route ? 2 : 1);
               if (e.route ? ready_1 : ready_0) begin
                  check("out_data", out_data, e.data);
                  void'(exp_q.pop_front());
                  xfer_cnt++;
                  if (e.data[13] && pkt_mdl != 16'hFFFF) pkt_mdl = pkt_mdl + 16'd1;
               end
            end
            if (in_valid && in_ready) begin
               ne.data  = in_data;
               ne.route = wr_head ? in_data[12] : wr_route;
               if (wr_head) wr_route = in_data[12];
               wr_head = in_data[13];
               exp_q.push_back(ne);
            end
         end
      end
   end

   // Random allocator back-pressure while enabled.
   initial begin
      forever begin
         @(negedge clk);
         if (rnd_on) begin
            ready_0 = 1'($urandom_range(0, 1));
            ready_1 = 1'($urandom_range(0, 1));
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int          base_x;
      logic [15:0] base_p;
      int          pat[4];
      logic [FW-1:0] d;
      int          len;
      logic        rt;

      // Reset state
      repeat (2) @(negedge clk);
      #2;
      check("rst_in_ready", in_ready, 0);
      check("rst_req", {req_1, req_0}, 0);
      check("rst_out_valid", out_valid, 0);
      @(negedge clk);
      reset = 1'b0;
      #2;
      check("post_rst_in_ready", in_ready, 1);
      check("post_rst_pkt_count", pkt_count, 0);

      // Two-flit packet on route 1
      @(negedge clk);
      ready_0 = 1'b0;
      ready_1 = 1'b1;
      base_x  = xfer_cnt;
      send(14'h1005);
      #2;
      check("s32_idle_req", {req_1, req_0}, 0);
      @(negedge clk);
      #2;
      check("s32_req_after_head", {req_1, req_0}, 2);
      check("s32_out_valid", out_valid, 1);
      @(negedge clk);
      send(14'h2006);
      drain("s32");
      check("s32_xfers", xfer_cnt - base_x, 2);
      check("s32_pkt_count", pkt_count, 1);
      check("s32_req_released", {req_1, req_0}, 0);

      // Fill to full with route-0 packet; ready_1 must be ignored
      ready_0 = 1'b0;
      ready_1 = 1'b1;
      for (int i = 0; i < 8; i++) send(14'h0100 + 14'(i));
      fork
         send(14'h2108);
         begin
            #2;
            check("s33_full", in_ready, 0);
            repeat (2) @(negedge clk);
            #2;
            check("s33_full_hold", in_ready, 0);
            check("s33_stall_valid", out_valid, 1);
            @(negedge clk);
            ready_0 = 1'b1;
         end
      join
      drain("s33");
      check("s33_pkt_count", pkt_count, 2);

      // Body gap mid-packet
      ready_0 = 1'b0;
      ready_1 = 1'b1;
      send(14'h1111);
      send(14'h0222);
      repeat (2) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         #2;
         check("s34_gap_req", {req_1, req_0}, 2);
         check("s34_gap_valid", out_valid, 0);
         @(negedge clk);
      end
      send(14'h2333);
      drain("s34");

      // Two single-flit packets: req_0, bubble, req_1
      ready_0 = 1'b1;
      ready_1 = 1'b1;
      base_p  = pkt_mdl;
      pat     = '{1, 0, 2, 0};
      send(14'h2ABC);
      send(14'h3001);
      for (int i = 0; i < 4; i++) begin
         #2;
         check("s35_req_seq", {req_1, req_0}, pat[i]);
         @(negedge clk);
      end
      check("s35_pkt_count", pkt_count, base_p + 16'd2);

      // Reset mid-packet with three buffered flits
      ready_0 = 1'b0;
      ready_1 = 1'b0;
      send(14'h0005);
      send(14'h0006);
      send(14'h0007);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #2;
      check("s36_req", {req_1, req_0}, 0);
      check("s36_out_valid", out_valid, 0);
      check("s36_pkt_count", pkt_count, 0);
      check("s36_in_ready", in_ready, 1);
      @(negedge clk);
      ready_0 = 1'b1;
      ready_1 = 1'b1;
      repeat (3) begin
         @(negedge clk);
         #2;
         check("s36_no_req", {req_1, req_0}, 0);
      end
      @(negedge clk);

      // Random packets under random back-pressure
      rnd_on = 1'b1;
      for (int p = 0; p < 40; p++) begin
         len = int'($urandom_range(1, 4));
         rt  = 1'($urandom_range(0, 1));
         for (int f = 0; f < len; f++) begin
            d[11:0] = 12'($urandom);
            d[12]   = (f == 0) ? rt : 1'($urandom_range(0, 1));
            d[13]   = (f == len - 1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(d);
         end
      end
      @(negedge clk);
      rnd_on  = 1'b0;
      ready_0 = 1'b1;
      ready_1 = 1'b1;
      drain("rand");

      // Saturation at 16'hFFFF
      #3;
      force dut.pkt_count_q = 16'hFFFF;
      pkt_mdl = 16'hFFFF;
      #1;
      release dut.pkt_count_q;
      @(negedge clk);
      send(14'h2555);
      drain("s37");
      #2;
      check("s37_saturate", pkt_count, 16'hFFFF);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/router_input_stage.md
ROUTER_INPUT_STAGE -- requirements
Module: router_input_stage

Interface
REQ-001 Parameter DEPTH, default 8, input FIFO entries; power of two, 4..32.
REQ-002 Parameter FLIT_W, default 14, flit width in bits.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  upstream link flit valid.
REQ-006 in_data  input  FLIT_W  upstream flit: [13] tail, [12] route (head flit only), [11:0] payload.
REQ-007 in_ready  output  1  FIFO can accept a flit.
REQ-008 req_0  output  1  packet request/lock toward output allocator 0.
REQ-009 req_1  output  1  packet request/lock toward output allocator 1.
REQ-010 ready_0  input  1  allocator 0 accepts out_data this cycle.
REQ-011 ready_1  input  1  allocator 1 accepts out_data this cycle.
REQ-012 out_valid  output  1  out_data holds a flit of the locked packet.
REQ-013 out_data  output  FLIT_W  FIFO head flit, passed unmodified.
REQ-014 pkt_count  output  16  packets forwarded since reset, saturating.

Function
REQ-015 in_ready SHALL equal !full && !reset; a write occurs when in_valid && in_ready.
REQ-016 The FIFO SHALL use log2(DEPTH)+1-bit read/write pointers; full = equal index bits with differing wrap bits; empty = pointers equal.
REQ-017 Simultaneous write and read SHALL keep occupancy unchanged; a write while full SHALL be impossible (in_ready low).
REQ-018 FSM states SHALL be IDLE and BUSY; route register SHALL be 1 bit.
REQ-019 In IDLE with FIFO non-empty, route SHALL latch head flit bit [12] and state SHALL go BUSY next cycle; no flit is dequeued in IDLE.
REQ-020 In BUSY, req_<route> SHALL be held high every cycle, including cycles with an empty FIFO; the other req SHALL be low.
REQ-021 out_valid SHALL equal BUSY && !empty; out_data SHALL always show the FIFO head.
REQ-022 A transfer SHALL occur when out_valid && ready_<route>; ready of the unselected allocator SHALL be ignored.
REQ-023 A transfer SHALL dequeue the head flit; if its bit [13] is 1, state SHALL go IDLE and pkt_count SHALL increment (hold at 16'hFFFF).
REQ-024 Head-to-first-transfer latency SHALL be 1 cycle minimum: flit in FIFO at cycle N, req high and out_valid at N+1.
REQ-025 req SHALL drop the cycle after the tail transfer; the next head SHALL be decoded in that IDLE cycle, giving one bubble between packets.
REQ-026 A single-flit packet (head with bit [13]=1) SHALL complete in one transfer.

Reset
REQ-027 While reset is high, at the next edge: pointers 0, FIFO empty, state IDLE, route 0, pkt_count 0.
REQ-028 Output values during and after reset: req_0=0, req_1=0, out_valid=0, in_ready=0 during reset and 1 the first cycle after; out_data don't-care.
REQ-029 Reset mid-packet SHALL discard all buffered flits and the partial packet; no req SHALL be asserted the cycle after reset deasserts.

Structure
REQ-030 A shared package SHALL hold FLIT_W, bit positions TAIL_BIT=13 and ROUTE_BIT=12, and the FSM state enum.
REQ-031 The FIFO SHALL be a separate sub-module router_fifo (DEPTH, FLIT_W parameters; wr/rd/full/empty ports).

Verification
REQ-032 Send head 0x1005 (route 1) then tail 0x2006 -> req_1 high from the cycle after the head lands, req_0 never high; with ready_1=1, two transfers occur, then pkt_count=1.
REQ-033 Fill FIFO with 9 back-to-back flits while ready_0=0 -> in_ready low after 8 writes; 9th flit is held until one transfer, then accepted, no loss or reorder.
REQ-034 Body flits delayed 5 cycles mid-packet -> req held high through the gap, out_valid low during the gap.
REQ-035 Single-flit packet 0x2ABC (route 0) then 0x3001 (route 1) -> req_0 for one transfer, one bubble cycle, then req_1; pkt_count=2.
REQ-036 Assert reset for 1 cycle mid-packet with 3 flits buffered -> next cycle FIFO empty, req_0=req_1=0, pkt_count=0.
REQ-037 Force pkt_count to 16'hFFFF, complete one more packet -> pkt_count stays 16'hFFFF.
